// File: rtl/croc_pkg.sv
// OBI bus payload types shared by the subordinate-side interconnect.
// Request carries the A channel plus req; response carries the R channel plus gnt/rvalid.
package croc_pkg;

    localparam int unsigned SbrAddrWidth = 32;
    localparam int unsigned SbrDataWidth = 32;
    localparam int unsigned SbrIdWidth   = 4;

    typedef struct packed {
        logic [SbrAddrWidth-1:0]   addr;
        logic                      we;
        logic [SbrDataWidth/8-1:0] be;
        logic [SbrDataWidth-1:0]   wdata;
        logic [SbrIdWidth-1:0]     aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [SbrDataWidth-1:0] rdata;
        logic [SbrIdWidth-1:0]   rid;
        logic                    err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain address map: rule type, default rule table and port count.
package user_pkg;

    localparam int unsigned NumSbr   = 4;
    localparam int unsigned NumRules = 4;

    // A rule matches start_addr <= addr < end_addr and routes to port idx.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam addr_map_rule_t Rule0 = '{idx: 32'd0, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000};
    localparam addr_map_rule_t Rule1 = '{idx: 32'd1, start_addr: 32'h2000_1000, end_addr: 32'h2000_2000};
    localparam addr_map_rule_t Rule2 = '{idx: 32'd2, start_addr: 32'h2000_2000, end_addr: 32'h2000_3000};
    localparam addr_map_rule_t Rule3 = '{idx: 32'd3, start_addr: 32'h2000_3000, end_addr: 32'h2000_4000};

    localparam addr_map_rule_t [NumRules-1:0] UserAddrMap = {Rule3, Rule2, Rule1, Rule0};

endpackage

// File: rtl/user_sbr_demux_err.sv
// Internal decode-error target: answers each accepted request one cycle later
// with an error response, and counts/flags every error handshake.
// Ports: clk_i/rst_ni; hs_i = error handshake this cycle; aid_i = request id;
//        rvalid_o/rid_o = error response; err_cnt_o = saturating count; err_irq_o = pulse.
module user_sbr_demux_err
    import croc_pkg::*;
#(
    parameter int unsigned IdWidth = SbrIdWidth
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               hs_i,
    input  logic [IdWidth-1:0] aid_i,
    output logic               rvalid_o,
    output logic [IdWidth-1:0] rid_o,
    output logic [15:0]        err_cnt_o,
    output logic               err_irq_o
);

    logic               pend_d, pend_q;
    logic [IdWidth-1:0] rid_d, rid_q;
    logic [15:0]        cnt_d, cnt_q;
    logic               irq_d, irq_q;

    // Next state: pending follows the handshake so back-to-back errors stream out.
    always_comb begin
        pend_d = hs_i;
        irq_d  = hs_i;
        rid_d  = rid_q;
        cnt_d  = cnt_q;
        if (hs_i) begin
            rid_d = aid_i;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            rid_q  <= '0;
            cnt_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            rid_q  <= rid_d;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
        end
    end

    assign rvalid_o  = pend_q;
    assign rid_o     = rid_q;
    assign err_cnt_o = cnt_q;
    assign err_irq_o = irq_q;

endmodule

// File: rtl/user_sbr_demux.sv
// OBI 1-to-NumSbr demultiplexer with address decode, in-order outstanding
// tracking and an internal decode-error target at index NumSbr.
// Ports: clk_i/rst_ni; addr_map_i = rule table; sbr_req_i/sbr_rsp_o = upstream;
//        mgr_req_o/mgr_rsp_i = per-port downstream; err_cnt_o/err_irq_o = error stats.
module user_sbr_demux
    import croc_pkg::*;
#(
    parameter int unsigned NumSbr      = user_pkg::NumSbr,
    parameter int unsigned NumRules    = user_pkg::NumRules,
    parameter int unsigned NumMaxTrans = 2,
    parameter logic [31:0] ErrRspData  = 32'hBADCAB1E,
    parameter type         obi_req_t   = sbr_obi_req_t,
    parameter type         obi_rsp_t   = sbr_obi_rsp_t,
    parameter type         rule_t      = user_pkg::addr_map_rule_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  rule_t    [NumRules-1:0] addr_map_i,
    input  obi_req_t                sbr_req_i,
    output obi_rsp_t                sbr_rsp_o,
    output obi_req_t [NumSbr-1:0]   mgr_req_o,
    input  obi_rsp_t [NumSbr-1:0]   mgr_rsp_i,
    output logic     [15:0]         err_cnt_o,
    output logic                    err_irq_o
);

    localparam int unsigned SelW = $clog2(NumSbr + 1);
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);
    localparam int unsigned IdW  = SbrIdWidth;

    logic [SelW-1:0] sel_c;
    logic [SelW-1:0] sel_d, sel_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            allow_c;
    logic            sel_gnt_c;
    logic            gnt_c;
    logic            hs_c;
    logic            err_hs_c;
    logic            rvalid_c;
    logic            err_rvalid;
    logic [IdW-1:0]  err_rid;

    // Address decode: later (higher-numbered) matching rules override earlier ones.
    always_comb begin
        sel_c = SelW'(NumSbr);
        for (int unsigned r = 0; r < NumRules; r++) begin
            if ((sbr_req_i.a.addr >= addr_map_i[r].start_addr) &&
                (sbr_req_i.a.addr <  addr_map_i[r].end_addr)) begin
                sel_c = (addr_map_i[r].idx < 32'(NumSbr)) ? SelW'(addr_map_i[r].idx)
                                                          : SelW'(NumSbr);
            end
        end
    end

    // Same-target requests may pile up to NumMaxTrans; a target switch waits for drain.
    assign allow_c = (cnt_q == '0) ||
                     ((sel_c == sel_q) && (cnt_q < CntW'(NumMaxTrans)));

    // Broadcast A channel, steer req to the selected port only.
    always_comb begin
        sel_gnt_c = 1'b0;
        for (int unsigned i = 0; i < NumSbr; i++) begin
            mgr_req_o[i]     = sbr_req_i;
            mgr_req_o[i].req = sbr_req_i.req & allow_c & (sel_c == SelW'(i));
            if (sel_c == SelW'(i)) begin
                sel_gnt_c = mgr_rsp_i[i].gnt;
            end
        end
        if (sel_c == SelW'(NumSbr)) begin
            sel_gnt_c = 1'b1;
        end
    end

    assign gnt_c    = allow_c & sel_gnt_c;
    assign hs_c     = sbr_req_i.req & gnt_c;
    assign err_hs_c = hs_c & (sel_c == SelW'(NumSbr));

    // Response mux from the target of the in-flight burst; count == 0 masks stale rvalids.
    always_comb begin
        rvalid_c      = 1'b0;
        sbr_rsp_o     = '0;
        for (int unsigned i = 0; i < NumSbr; i++) begin
            if (sel_q == SelW'(i)) begin
                rvalid_c    = mgr_rsp_i[i].rvalid;
                sbr_rsp_o.r = mgr_rsp_i[i].r;
            end
        end
        if (sel_q == SelW'(NumSbr)) begin
            rvalid_c          = err_rvalid;
            sbr_rsp_o.r.rdata = ErrRspData;
            sbr_rsp_o.r.err   = 1'b1;
            sbr_rsp_o.r.rid   = err_rid;
        end
        rvalid_c         = rvalid_c & (cnt_q != '0);
        sbr_rsp_o.rvalid = rvalid_c;
        sbr_rsp_o.gnt    = gnt_c;
    end

    // Outstanding bookkeeping.
    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        if (hs_c) begin
            sel_d = sel_c;
        end
        case ({hs_c, rvalid_c})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    user_sbr_demux_err #(
        .IdWidth (IdW)
    ) u_err (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .hs_i      (err_hs_c),
        .aid_i     (sbr_req_i.a.aid),
        .rvalid_o  (err_rvalid),
        .rid_o     (err_rid),
        .err_cnt_o (err_cnt_o),
        .err_irq_o (err_irq_o)
    );

endmodule

// File: tb/tb_user_sbr_demux.sv
// Self-checking bench for user_sbr_demux: directed scenarios plus a random phase,
// all checked against a queue-based reference model of the demux behaviour.
module tb_user_sbr_demux;
    import croc_pkg::*;

    localparam int unsigned TbSbr   = 4;
    localparam int unsigned TbRules = 4;
    localparam int unsigned TbMaxT  = 2;
    localparam int unsigned ErrIdx  = TbSbr;

    localparam logic [31:0] A0   = 32'h2000_0004;
    localparam logic [31:0] A1   = 32'h2000_1010;
    localparam logic [31:0] AERR = 32'h3000_0000;

    logic clk;
    logic rst_n;

    user_pkg::addr_map_rule_t [TbRules-1:0] addr_map;
    sbr_obi_req_t                           sbr_req;
    sbr_obi_rsp_t                           sbr_rsp;
    sbr_obi_req_t [TbSbr-1:0]               mgr_req;
    sbr_obi_rsp_t [TbSbr-1:0]               mgr_rsp;
    logic [15:0]                            err_cnt;
    logic                                   err_irq;

    user_sbr_demux #(
        .NumSbr      (TbSbr),
        .NumRules    (TbRules),
        .NumMaxTrans (TbMaxT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .addr_map_i (addr_map),
        .sbr_req_i  (sbr_req),
        .sbr_rsp_o  (sbr_rsp),
        .mgr_req_o  (mgr_req),
        .mgr_rsp_i  (mgr_rsp),
        .err_cnt_o  (err_cnt),
        .err_irq_o  (err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rule table as seen by the model.
    logic [31:0] rs [TbRules];
    logic [31:0] re [TbRules];
    logic [31:0] ri [TbRules];

    // Reference model state.
    int unsigned q[$];          // target of every outstanding transaction, oldest first
    bit          err_due;       // an error response is owed this cycle
    logic [3:0]  err_rid_m;
    int unsigned err_cnt_m;
    bit          irq_m;

    int n_chk;
    int n_fail;

    // Per-cycle stimulus and observations.
    logic        c_req;
    logic [31:0] c_addr;
    logic [3:0]  c_gnt;
    logic [3:0]  c_rv;
    logic        obs_gnt;
    logic        obs_rvalid;
    logic        obs_err;
    logic [31:0] obs_rdata;
    logic [3:0]  obs_req;
    logic [31:0] stim_rdata0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_decode(input logic [31:0] a);
        int unsigned t;
        t = ErrIdx;
        for (int r = 0; r < int'(TbRules); r++) begin
            if (a >= rs[r] && a < re[r]) t = (ri[r] < TbSbr) ? int'(ri[r]) : ErrIdx;
        end
        return t;
    endfunction

    task automatic set_c(input logic req, input logic [31:0] addr,
                         input logic [3:0] gnt, input logic [3:0] rv);
        c_req  = req;
        c_addr = addr;
        c_gnt  = gnt;
        c_rv   = rv;
    endtask

    // One clock cycle: drive, compare combinational outputs, advance model, compare registered outputs.
    task automatic run_cycle();
        int unsigned sel_m;
        int unsigned front;
        bit          allow_m;
        bit          gnt_m;
        bit          rv_m;
        bit          due_nx;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_rid;
        logic        exp_err;
        sbr_req.req     = c_req;
        sbr_req.a.addr  = c_addr;
        sbr_req.a.aid   = 4'($urandom);
        sbr_req.a.we    = 1'($urandom);
        sbr_req.a.be    = 4'($urandom);
        sbr_req.a.wdata = $urandom;
        for (int p = 0; p < int'(TbSbr); p++) begin
            mgr_rsp[p].gnt     = c_gnt[p];
            mgr_rsp[p].rvalid  = c_rv[p];
            mgr_rsp[p].r.rdata = $urandom;
            mgr_rsp[p].r.rid   = 4'($urandom);
            mgr_rsp[p].r.err   = 1'($urandom);
        end
        stim_rdata0 = mgr_rsp[0].r.rdata;
        #1;
        sel_m   = ref_decode(c_addr);
        allow_m = (q.size() == 0) || (q[$] == sel_m && q.size() < TbMaxT);
        gnt_m   = allow_m && ((sel_m == ErrIdx) ? 1'b1 : c_gnt[sel_m[1:0]]);
        check("gnt", 96'(sbr_rsp.gnt), 96'(gnt_m));
        for (int p = 0; p < int'(TbSbr); p++) begin
            check($sformatf("mgr_req%0d", p), 96'(mgr_req[p].req),
                  96'(c_req && allow_m && sel_m == p));
            check($sformatf("mgr_a%0d", p), 96'(mgr_req[p].a), 96'(sbr_req.a));
            obs_req[p] = mgr_req[p].req;
        end
        rv_m      = 1'b0;
        exp_rdata = '0;
        exp_rid   = '0;
        exp_err   = 1'b0;
        if (q.size() > 0) begin
            front = q[0];
            if (front == ErrIdx) begin
                rv_m      = err_due;
                exp_rdata = 32'hBADCAB1E;
                exp_rid   = err_rid_m;
                exp_err   = 1'b1;
            end else begin
                rv_m      = c_rv[front];
                exp_rdata = mgr_rsp[front].r.rdata;
                exp_rid   = mgr_rsp[front].r.rid;
                exp_err   = mgr_rsp[front].r.err;
            end
        end
        check("rvalid", 96'(sbr_rsp.rvalid), 96'(rv_m));
        if (rv_m) begin
            check("rdata", 96'(sbr_rsp.r.rdata), 96'(exp_rdata));
            check("rid",   96'(sbr_rsp.r.rid),   96'(exp_rid));
            check("rerr",  96'(sbr_rsp.r.err),   96'(exp_err));
        end
        obs_gnt    = sbr_rsp.gnt;
        obs_rvalid = sbr_rsp.rvalid;
        obs_rdata  = sbr_rsp.r.rdata;
        obs_err    = sbr_rsp.r.err;
        if (rv_m) void'(q.pop_front());
        irq_m  = 1'b0;
        due_nx = 1'b0;
        if (c_req && gnt_m) begin
            q.push_back(sel_m);
            if (sel_m == ErrIdx) begin
                due_nx    = 1'b1;
                err_rid_m = sbr_req.a.aid;
                irq_m     = 1'b1;
                if (err_cnt_m < 65535) err_cnt_m++;
            end
        end
        err_due = due_nx;
        @(posedge clk);
        #1;
        check("err_irq", 96'(err_irq), 96'(irq_m));
        check("err_cnt", 96'(err_cnt), 96'(err_cnt_m));
    endtask

    // Asynchronous reset asserted mid-cycle, released away from the clock edge.
    task automatic do_reset();
        sbr_req.req = 1'b0;
        mgr_rsp     = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_err_cnt", 96'(err_cnt), 96'(0));
        check("rst_err_irq", 96'(err_irq), 96'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        q.delete();
        err_due   = 1'b0;
        irq_m     = 1'b0;
        err_cnt_m = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        err_rid_m = '0;
        rst_n     = 1'b1;
        sbr_req   = '0;
        mgr_rsp   = '0;
        // rule3 overlaps rule0 (tests priority), rule2 points past the last port.
        rs[0] = 32'h2000_0000; re[0] = 32'h2000_1000; ri[0] = 32'd0;
        rs[1] = 32'h2000_1000; re[1] = 32'h2000_2000; ri[1] = 32'd1;
        rs[2] = 32'h2000_2000; re[2] = 32'h2000_3000; ri[2] = 32'd9;
        rs[3] = 32'h2000_0800; re[3] = 32'h2000_0C00; ri[3] = 32'd3;
        for (int r = 0; r < int'(TbRules); r++) begin
            addr_map[r] = '{idx: ri[r], start_addr: rs[r], end_addr: re[r]};
        end
        #3;
        do_reset();

        // Plain read to port 0, response forwarded unchanged with zero added latency.
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        check("d_port0_req", 96'(obs_req), 96'(4'b0001));
        set_c(1'b0, A0, 4'b0000, 4'b0001); run_cycle();
        check("d_port0_rdata", 96'(obs_rdata), 96'(stim_rdata0));
        // Overlapping rule: higher-numbered rule wins.
        set_c(1'b1, 32'h2000_0900, 4'b1000, 4'b0000); run_cycle();
        check("d_prio_req", 96'(obs_req), 96'(4'b1000));
        set_c(1'b0, A0, 4'b0000, 4'b1000); run_cycle();

        // Unmapped read: same-cycle grant, error response next cycle.
        set_c(1'b1, AERR, 4'b0000, 4'b0000); run_cycle();
        check("d_err_gnt", 96'(obs_gnt), 96'(1));
        check("d_err_cnt", 96'(err_cnt), 96'(16'd1));
        check("d_err_irq", 96'(err_irq), 96'(1));
        set_c(1'b0, AERR, 4'b0000, 4'b0000); run_cycle();
        check("d_err_rvalid", 96'(obs_rvalid), 96'(1));
        check("d_err_rdata", 96'(obs_rdata), 96'(32'hBADCAB1E));
        check("d_err_flag", 96'(obs_err), 96'(1));
        check("d_err_irq_drop", 96'(err_irq), 96'(0));
        // Rule whose idx is out of range is an error as well.
        set_c(1'b1, 32'h2000_2040, 4'b1111, 4'b0000); run_cycle();
        set_c(1'b0, A0, 4'b0000, 4'b0000); run_cycle();

        // Outstanding limit: third request stalls until a response returns.
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        check("d_limit_gnt", 96'(obs_gnt), 96'(0));
        set_c(1'b1, A0, 4'b0001, 4'b0001); run_cycle();
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        check("d_limit_release", 96'(obs_gnt), 96'(1));
        set_c(1'b0, A0, 4'b0000, 4'b0001); run_cycle();
        set_c(1'b0, A0, 4'b0000, 4'b0001); run_cycle();

        // Target switch waits for drain.
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        set_c(1'b1, A1, 4'b0010, 4'b0000); run_cycle();
        check("d_switch_stall", 96'(obs_req), 96'(4'b0000));
        set_c(1'b1, A1, 4'b0010, 4'b0001); run_cycle();
        check("d_switch_stall2", 96'(obs_req), 96'(4'b0000));
        set_c(1'b1, A1, 4'b0010, 4'b0000); run_cycle();
        check("d_switch_go", 96'(obs_req), 96'(4'b0010));
        set_c(1'b0, A1, 4'b0000, 4'b0010); run_cycle();

        // Handshake and response together keep the count; a switch is still blocked.
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        set_c(1'b1, A0, 4'b0001, 4'b0001); run_cycle();
        set_c(1'b1, A1, 4'b0010, 4'b0000); run_cycle();
        check("d_same_cycle", 96'(obs_req), 96'(4'b0000));
        set_c(1'b0, A0, 4'b0000, 4'b0001); run_cycle();

        // Reset mid-transaction drops state; stale responses are not forwarded.
        set_c(1'b1, AERR, 4'b0000, 4'b0000); run_cycle();
        set_c(1'b1, A0, 4'b0000, 4'b0000); run_cycle();
        set_c(1'b1, A0, 4'b0001, 4'b0000); run_cycle();
        do_reset();
        set_c(1'b0, A0, 4'b0000, 4'b0001); run_cycle();
        check("d_stale_rvalid", 96'(obs_rvalid), 96'(0));
        set_c(1'b1, A1, 4'b0010, 4'b0000); run_cycle();
        check("d_post_rst_gnt", 96'(obs_gnt), 96'(1));
        set_c(1'b0, A1, 4'b0000, 4'b0010); run_cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [3:0]  rv;
            case ($urandom_range(0, 5))
                0:       a = 32'h2000_0000 + 32'($urandom_range(0, 32'h7FF));
                1:       a = 32'h2000_1000 + 32'($urandom_range(0, 32'hFFF));
                2:       a = 32'h2000_0800 + 32'($urandom_range(0, 32'h3FF));
                3:       a = 32'h2000_2000 + 32'($urandom_range(0, 32'hFFF));
                4:       a = 32'h2000_0C00 + 32'($urandom_range(0, 32'h3FF));
                default: a = $urandom;
            endcase
            for (int p = 0; p < int'(TbSbr); p++) begin
                if (q.size() > 0 && q[0] == p) rv[p] = 1'($urandom);
                else                           rv[p] = ($urandom_range(0, 3) == 0);
            end
            set_c(($urandom_range(0, 3) != 0), a, 4'($urandom), rv);
            run_cycle();
        end
        set_c(1'b0, A0, 4'b0000, 4'b1111);
        for (int n = 0; n < 4; n++) run_cycle();

        // Saturating error counter.
        do_reset();
        sbr_req.req    = 1'b1;
        sbr_req.a.addr = AERR;
        mgr_rsp        = '0;
        repeat (65535) @(posedge clk);
        #1 sbr_req.req = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        err_due   = 1'b0;
        err_cnt_m = 65535;
        check("d_sat_preload", 96'(err_cnt), 96'(16'hFFFF));
        set_c(1'b1, AERR, 4'b0000, 4'b0000); run_cycle();
        check("d_sat_hold", 96'(err_cnt), 96'(16'hFFFF));
        check("d_sat_irq", 96'(err_irq), 96'(1));
        set_c(1'b0, AERR, 4'b0000, 4'b0000); run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
